// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the CPU character I/O controller
package io_pkg;

  localparam int IO_CHAR_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GETC_WAIT = 3'd1,
    GETC_POP  = 3'd2,
    PUTC_WAIT = 3'd3,
    DONE      = 3'd4
  } io_ctrl_state_t;

  // Wait counter must hold 0..TIMEOUT-1 and still be at least one bit wide.
  function automatic int io_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - CPU getc/putc request sequencer in front of a device byte FIFO pair
module io_ctrl
  import io_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_getc,
  input  logic                 cpu_putc,
  input  logic [IO_CHAR_W-1:0] cpu_putc_char,
  output logic                 cpu_busy,
  output logic                 cpu_done,
  output logic [IO_CHAR_W-1:0] cpu_getc_char,
  output logic                 cpu_timeout,
  output logic                 cpu_ovr,
  input  logic                 cpu_ovr_clr,
  input  logic                 getc_en,
  input  logic [IO_CHAR_W-1:0] getc_char,
  output logic                 getc_pop,
  output logic                 putc_push,
  output logic [IO_CHAR_W-1:0] putc_char,
  input  logic                 putc_push_done,
  input  logic                 inbuf_full
);

  localparam int CNT_W = io_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  io_ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pop_q, pop_d;
  logic                 push_q, push_d;
  logic [IO_CHAR_W-1:0] pchar_q, pchar_d;
  logic [IO_CHAR_W-1:0] gchar_q, gchar_d;
  logic                 tout_q, tout_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pop_q   <= 1'b0;
      push_q  <= 1'b0;
      pchar_q <= '0;
      gchar_q <= '0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      pchar_q <= pchar_d;
      gchar_q <= gchar_d;
      tout_q  <= tout_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_d   = pop_q;
    push_d  = push_q;
    pchar_d = pchar_q;
    gchar_d = gchar_q;
    tout_d  = tout_q;

    // A full-buffer observation outranks a simultaneous clear so no event is lost.
    ovr_d = inbuf_full ? 1'b1 : (cpu_ovr_clr ? 1'b0 : ovr_q);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_getc) begin
          state_d = GETC_WAIT;
          tout_d  = 1'b0;
        end else if (cpu_putc) begin
          state_d = PUTC_WAIT;
          pchar_d = cpu_putc_char;
          push_d  = 1'b1;
          tout_d  = 1'b0;
        end
      end
      GETC_WAIT: begin
        if (getc_en) begin
          gchar_d = getc_char;
          pop_d   = 1'b1;
          state_d = GETC_POP;
        end else if (TIMEOUT > 0) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            gchar_d = '0;
            tout_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GETC_POP: begin
        // Extra cycle lets the device advance its front byte before the next getc.
        pop_d   = 1'b0;
        state_d = DONE;
      end
      PUTC_WAIT: begin
        if (putc_push_done) begin
          push_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_busy      = (state_q != IDLE);
  assign cpu_done      = (state_q == DONE);
  assign cpu_getc_char = gchar_q;
  assign cpu_timeout   = tout_q;
  assign cpu_ovr       = ovr_q;
  assign getc_pop      = pop_q;
  assign putc_push     = push_q;
  assign putc_char     = pchar_q;

endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - self-checking bench for io_ctrl with transaction-level reference model
module tb_io_ctrl;

  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_getc = 1'b0;
  logic       cpu_putc = 1'b0;
  logic [7:0] cpu_putc_char = 8'h00;
  logic       cpu_busy;
  logic       cpu_done;
  logic [7:0] cpu_getc_char;
  logic       cpu_timeout;
  logic       cpu_ovr;
  logic       cpu_ovr_clr = 1'b0;
  logic       getc_en = 1'b0;
  logic [7:0] getc_char = 8'h00;
  logic       getc_pop;
  logic       putc_push;
  logic [7:0] putc_char;
  logic       putc_push_done = 1'b0;
  logic       inbuf_full = 1'b0;

  io_ctrl #(.TIMEOUT(TOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_getc       (cpu_getc),
    .cpu_putc       (cpu_putc),
    .cpu_putc_char  (cpu_putc_char),
    .cpu_busy       (cpu_busy),
    .cpu_done       (cpu_done),
    .cpu_getc_char  (cpu_getc_char),
    .cpu_timeout    (cpu_timeout),
    .cpu_ovr        (cpu_ovr),
    .cpu_ovr_clr    (cpu_ovr_clr),
    .getc_en        (getc_en),
    .getc_char      (getc_char),
    .getc_pop       (getc_pop),
    .putc_push      (putc_push),
    .putc_char      (putc_char),
    .putc_push_done (putc_push_done),
    .inbuf_full     (inbuf_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction counted in cycles ("age") since it was accepted.
  bit         m_busy, m_getc, m_resolved, m_tout, m_push, m_ovr;
  int         m_age, m_pop_age, m_done_age;
  logic [7:0] m_char, m_pchar;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_getc <= 0; m_resolved <= 0; m_tout <= 0; m_push <= 0; m_ovr <= 0;
      m_age <= 0; m_pop_age <= 0; m_done_age <= 0; m_char <= 8'h00; m_pchar <= 8'h00;
    end else begin
      if (inbuf_full) m_ovr <= 1;
      else if (cpu_ovr_clr) m_ovr <= 0;
      if (!m_busy) begin
        if (cpu_getc || cpu_putc) begin
          m_busy <= 1; m_age <= 1; m_resolved <= 0; m_pop_age <= 0; m_done_age <= 0; m_tout <= 0;
          m_getc <= cpu_getc;
          if (!cpu_getc) begin
            m_push  <= 1;
            m_pchar <= cpu_putc_char;
          end
        end
      end else if (m_age == m_done_age) begin
        m_busy <= 0; m_pop_age <= 0; m_done_age <= 0;
      end else begin
        m_age <= m_age + 1;
        if (!m_resolved) begin
          if (m_getc) begin
            if (getc_en) begin
              m_resolved <= 1; m_char <= getc_char;
              m_pop_age <= m_age + 1; m_done_age <= m_age + 2;
            end else if (TOUT > 0 && m_age == TOUT) begin
              m_resolved <= 1; m_char <= 8'h00; m_tout <= 1; m_done_age <= m_age + 1;
            end
          end else if (putc_push_done) begin
            m_resolved <= 1; m_push <= 0; m_done_age <= m_age + 1;
          end
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("busy", cpu_busy, m_busy);
    check("done", cpu_done, m_busy && m_age == m_done_age);
    check("getc_pop", getc_pop, m_busy && m_age == m_pop_age);
    check("putc_push", putc_push, m_push);
    check("putc_char", putc_char, m_pchar);
    check("cpu_getc_char", cpu_getc_char, m_char);
    check("cpu_timeout", cpu_timeout, m_tout);
    check("cpu_ovr", cpu_ovr, m_ovr);
    if (getc_pop) pop_cnt++;
    if (putc_push) push_cnt++;
    if (cpu_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int c, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        lat = cyc - c;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no cpu_done, expected one within 40 cycles at cycle %0d", cyc);
    end
  endtask

  initial begin
    int c, lat, pb, ub, db;

    repeat (2) tick();
    check("rst_busy", cpu_busy, 0);
    check("rst_done", cpu_done, 0);
    check("rst_push", putc_push, 0);
    check("rst_pop", getc_pop, 0);
    check("rst_gchar", cpu_getc_char, 8'h00);
    check("rst_pchar", putc_char, 8'h00);
    check("rst_ovr", cpu_ovr, 0);
    check("rst_tout", cpu_timeout, 0);
    rst = 1'b1;
    tick();

    // getc with byte already available
    getc_en = 1; getc_char = 8'h41; pb = pop_cnt;
    c = cyc; cpu_getc = 1;
    tick(); cpu_getc = 0;
    wait_done(c, lat);
    check("getc_lat", lat, 3);
    check("getc_char", cpu_getc_char, 8'h41);
    check("getc_tout", cpu_timeout, 0);
    tick(); getc_en = 0; getc_char = 8'h00;
    tick();
    check("getc_pops", pop_cnt - pb, 1);

    // putc acknowledged 4 cycles after the request
    ub = push_cnt; db = done_cnt;
    c = cyc; cpu_putc = 1; cpu_putc_char = 8'h5A;
    tick(); cpu_putc = 0; cpu_putc_char = 8'h00;
    repeat (3) tick();
    putc_push_done = 1;
    tick(); putc_push_done = 0;
    wait_done(c, lat);
    check("putc_lat", lat, 5);
    repeat (3) tick();
    check("putc_push_cycles", push_cnt - ub, 4);
    check("putc_dones", done_cnt - db, 1);
    check("putc_char_held", putc_char, 8'h5A);

    // getc with no byte: timeout after TOUT wait cycles
    pb = pop_cnt;
    c = cyc; cpu_getc = 1;
    tick(); cpu_getc = 0;
    wait_done(c, lat);
    check("tout_lat", lat, TOUT + 1);
    check("tout_flag", cpu_timeout, 1);
    check("tout_char", cpu_getc_char, 8'h00);
    tick();
    check("tout_pops", pop_cnt - pb, 0);

    // byte appears on the last wait cycle: normal path wins over timeout
    pb = pop_cnt;
    c = cyc; cpu_getc = 1;
    tick(); cpu_getc = 0;
    repeat (TOUT - 1) tick();
    getc_en = 1; getc_char = 8'h77;
    wait_done(c, lat);
    check("edge_lat", lat, TOUT + 2);
    check("edge_tout", cpu_timeout, 0);
    check("edge_char", cpu_getc_char, 8'h77);
    tick(); getc_en = 0;
    check("edge_pops", pop_cnt - pb, 1);

    // simultaneous requests, then requests held while busy
    ub = push_cnt; db = done_cnt;
    c = cyc; cpu_getc = 1; cpu_putc = 1; cpu_putc_char = 8'hEE;
    repeat (3) tick();
    cpu_getc = 0; cpu_putc = 0; getc_en = 1; getc_char = 8'h33;
    wait_done(c, lat);
    check("both_lat", lat, 5);
    check("both_char", cpu_getc_char, 8'h33);
    tick(); getc_en = 0;
    repeat (3) tick();
    check("both_no_push", push_cnt - ub, 0);
    check("both_dones", done_cnt - db, 1);
    check("both_pchar", putc_char, 8'h5A);

    // asynchronous reset in the middle of a putc
    cpu_putc = 1; cpu_putc_char = 8'hA5;
    tick(); cpu_putc = 0;
    repeat (2) tick();
    @(negedge clk); #2;
    check("pre_rst_push", putc_push, 1);
    rst = 0;
    #1;
    check("arst_busy", cpu_busy, 0);
    check("arst_push", putc_push, 0);
    check("arst_pchar", putc_char, 8'h00);
    @(posedge clk); #1; rst = 1;
    tick();
    check("post_rst_busy", cpu_busy, 0);

    // sticky overrun flag
    inbuf_full = 1;
    tick(); inbuf_full = 0;
    check("ovr_set", cpu_ovr, 1);
    repeat (2) tick();
    check("ovr_sticky", cpu_ovr, 1);
    cpu_ovr_clr = 1; inbuf_full = 1;
    tick(); inbuf_full = 0;
    check("ovr_set_wins", cpu_ovr, 1);
    tick(); cpu_ovr_clr = 0;
    check("ovr_cleared", cpu_ovr, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200000 time units");
    $fatal(1);
  end

endmodule
